// File: rtl/pipe_elastic_buffer_pkg.sv
// Shared constants and types for the pipeline elastic output buffer.
// The datapath width and default depth are common to the pipeline stage
// and the buffer, so both pick them up from here.
package pipe_elastic_buffer_pkg;

    // Datapath word width of the pipeline.
    localparam int unsigned PIPE_WIDTH = 32;

    // Default number of buffered words (power of two, at least 2).
    localparam int unsigned PIPE_DEPTH = 4;

    // Per-cycle buffer operation, derived from the two handshakes.
    typedef enum logic [1:0] {
        BUF_IDLE = 2'b00,
        BUF_POP  = 2'b01,
        BUF_PUSH = 2'b10,
        BUF_BOTH = 2'b11
    } buf_op_e;

    // Classify the cycle from the qualified push and pop strobes.
    function automatic buf_op_e decode_op(input logic push, input logic pop);
        buf_op_e op;
        if (push && pop) begin
            op = BUF_BOTH;
        end else if (push) begin
            op = BUF_PUSH;
        end else if (pop) begin
            op = BUF_POP;
        end else begin
            op = BUF_IDLE;
        end
        return op;
    endfunction

endpackage

// File: rtl/pipe_buf_ram.sv
// Storage array for the elastic buffer: DEPTH x WIDTH registers with one
// synchronous write port and one asynchronous read port. Contents are
// deliberately not reset; only the surrounding pointers are.
module pipe_buf_ram
    import pipe_elastic_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_WIDTH,
    parameter int unsigned DEPTH = PIPE_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the offered word into its slot on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_elastic_buffer.sv
// Elastic output buffer placed after the stallable pipeline stage.
// Absorbs up to DEPTH words so consumer back-pressure does not stall the
// pipeline at once, and presents the head word first-word-fall-through.
// in_allow is a function of registered occupancy only, so there is no
// combinational path from out_allow back to the pipeline.
module pipe_elastic_buffer
    import pipe_elastic_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_WIDTH,
    parameter int unsigned DEPTH = PIPE_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   validin,
    input  logic [WIDTH-1:0]       datain,
    output logic                   in_allow,
    output logic                   validout,
    output logic [WIDTH-1:0]       dataout,
    input  logic                   out_allow,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rd_data;
    logic             push;
    logic             pop;
    buf_op_e          op;

    // Handshake flags from registered occupancy.
    assign in_allow = (count != FULL_COUNT);
    assign validout = (count != '0);

    assign push = validin && in_allow;
    assign pop  = validout && out_allow;
    assign op   = decode_op(push, pop);

    // Head word is forced to zero while the buffer is empty.
    assign dataout = validout ? rd_data : '0;

    pipe_buf_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (datain),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Pointer and occupancy update; flush overrides any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            unique case (op)
                BUF_PUSH: begin
                    wr_ptr <= wr_ptr + AW'(1);
                    count  <= count + CW'(1);
                end
                BUF_POP: begin
                    rd_ptr <= rd_ptr + AW'(1);
                    count  <= count - CW'(1);
                end
                BUF_BOTH: begin
                    wr_ptr <= wr_ptr + AW'(1);
                    rd_ptr <= rd_ptr + AW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_elastic_buffer.sv
// Directed bench for pipe_elastic_buffer: a table of per-cycle stimulus
// with hand-computed expected outputs, plus hand-written reset sequences.
module tb_pipe_elastic_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        validin;
    logic [31:0] datain;
    logic        in_allow;
    logic        validout;
    logic [31:0] dataout;
    logic        out_allow;
    logic [2:0]  count;

    int checks;
    int failures;

    typedef struct {
        logic        flush;
        logic        validin;
        logic [31:0] datain;
        logic        out_allow;
        logic        exp_validout;
        logic [31:0] exp_dataout;
        logic [2:0]  exp_count;
        logic        exp_in_allow;
    } vec_t;

    vec_t vq[$];

    pipe_elastic_buffer #(
        .WIDTH (32),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .validin   (validin),
        .datain    (datain),
        .in_allow  (in_allow),
        .validout  (validout),
        .dataout   (dataout),
        .out_allow (out_allow),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] ed,
                             input logic [2:0] ec, input logic ea);
        check({tag, ".validout"}, 32'(validout), 32'(ev));
        check({tag, ".dataout"},  dataout,       ed);
        check({tag, ".count"},    32'(count),    32'(ec));
        check({tag, ".in_allow"}, 32'(in_allow), 32'(ea));
    endtask

    task automatic add(input logic fl, input logic v, input logic [31:0] d, input logic oa,
                       input logic ev, input logic [31:0] ed, input logic [2:0] ec, input logic ea);
        vec_t t;
        t.flush = fl; t.validin = v; t.datain = d; t.out_allow = oa;
        t.exp_validout = ev; t.exp_dataout = ed; t.exp_count = ec; t.exp_in_allow = ea;
        vq.push_back(t);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        flush = 1'b0;
        validin = 1'b0;
        datain = '0;
        out_allow = 1'b0;

        //   fl v  data oa   ev dout c  ia
        // single word through an empty buffer
        add(0, 1,   4, 1,   1,   4, 1, 1);
        add(0, 0,   0, 1,   0,   0, 0, 1);
        // fill to full with consumer stalled; fifth word refused
        add(0, 1,  18, 0,   1,  18, 1, 1);
        add(0, 1,  24, 0,   1,  18, 2, 1);
        add(0, 1,  28, 0,   1,  18, 3, 1);
        add(0, 1,  32, 0,   1,  18, 4, 0);
        add(0, 1,  36, 0,   1,  18, 4, 0);
        // full with pop: bubble, then push+pop, then drain
        add(0, 1,  36, 1,   1,  24, 3, 1);
        add(0, 1,  36, 1,   1,  28, 3, 1);
        add(0, 0,   0, 1,   1,  32, 2, 1);
        add(0, 0,   0, 1,   1,  36, 1, 1);
        add(0, 0,   0, 1,   0,   0, 0, 1);
        // prefill to 2, then 6 cycles of push+pop across pointer wrap
        add(0, 1, 101, 0,   1, 101, 1, 1);
        add(0, 1, 102, 0,   1, 101, 2, 1);
        add(0, 1,   1, 1,   1, 102, 2, 1);
        add(0, 1,   2, 1,   1,   1, 2, 1);
        add(0, 1,   3, 1,   1,   2, 2, 1);
        add(0, 1,   4, 1,   1,   3, 2, 1);
        add(0, 1,   5, 1,   1,   4, 2, 1);
        add(0, 1,   6, 1,   1,   5, 2, 1);
        // grow to 3, flush while offering 99, 99 never appears
        add(0, 1,   7, 0,   1,   5, 3, 1);
        add(1, 1,  99, 1,   0,   0, 0, 1);
        add(0, 0,  99, 0,   0,   0, 0, 1);
        add(0, 1,   8, 0,   1,   8, 1, 1);
        add(0, 0,   0, 1,   0,   0, 0, 1);

        // Reset state while rst is held.
        #1;
        check_all("reset", 1'b0, 32'd0, 3'd0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            flush     = vq[i].flush;
            validin   = vq[i].validin;
            datain    = vq[i].datain;
            out_allow = vq[i].out_allow;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vq[i].exp_validout, vq[i].exp_dataout,
                      vq[i].exp_count, vq[i].exp_in_allow);
            @(negedge clk);
        end

        // Asynchronous reset between edges at count=2.
        flush = 1'b0;
        validin = 1'b1; out_allow = 1'b0; datain = 32'd11;
        @(posedge clk); #1;
        @(negedge clk);
        datain = 32'd12;
        @(posedge clk); #1;
        check_all("prerst", 1'b1, 32'd11, 3'd2, 1'b1);
        validin = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 1'b0, 32'd0, 3'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        validin = 1'b1; datain = 32'd7; out_allow = 1'b0;
        @(posedge clk); #1;
        check_all("post_rst", 1'b1, 32'd7, 3'd1, 1'b1);
        @(negedge clk);
        validin = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
